cpu_control_pipe: RTL and testbench

- Next-generation main control unit for the 5-stage MIPS core.
- Decodes the ID-stage opcode into a widened control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Supports hazard-unit stalls and branch flushes.
- An illegal opcode raises a trap request (with EPC capture) instead of issuing an inert control word.
- The ALUOp field is widened to cover the extended opcode set.

---
 rtl/cpu_control_pipe.sv | 139 +++++++++++++
 tb/tb_cpu_control_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_pipe.sv
// cpu_control_pipe: main control unit for the 5-stage MIPS core.
// Decodes the ID-stage opcode into a control bundle and pipelines it through
// the ID/EX, EX/MEM and MEM/WB control registers.
// It handles hazard stalls and branch flushes.
// An accepted illegal opcode raises a trap request, captures its PC in epc__o
// and bumps a saturating illegal-opcode counter.
// Ports:
//   clock__i, reset__i           clock, synchronous active-high reset
//   valid__i, opcode__i, pc__i   ID-stage instruction
//   stall__i, flush__i           hazard-unit bubble request, branch-taken kill
//   trap_ack__i                  fetch has redirected to the handler
//   {ex,mem,wb}_ctrl__o/_valid__o  per-stage control bundle and valid
//   trap__o, trap_vector__o, epc__o, illegal_count__o  trap interface
// Bundle layout (MSB..LSB): RegDst Branch BranchNe MemRead MemToReg MemWrite
// ALUSrc RegWrite ALUOp[ALUOP_W-1:0].
module cpu_control_pipe #(
    parameter int unsigned     PC_W        = 32,
    parameter int unsigned     ALUOP_W     = 4,
    parameter logic [PC_W-1:0] TRAP_VECTOR = PC_W'(32'h0000_0100),
    parameter int unsigned     CNT_W       = 8
) (
    input  logic               clock__i,
    input  logic               reset__i,
    input  logic               valid__i,
    input  logic [5:0]         opcode__i,
    input  logic [PC_W-1:0]    pc__i,
    input  logic               stall__i,
    input  logic               flush__i,
    input  logic               trap_ack__i,
    output logic [ALUOP_W+7:0] ex_ctrl__o,
    output logic               ex_valid__o,
    output logic [ALUOP_W+7:0] mem_ctrl__o,
    output logic               mem_valid__o,
    output logic [ALUOP_W+7:0] wb_ctrl__o,
    output logic               wb_valid__o,
    output logic               trap__o,
    output logic [PC_W-1:0]    trap_vector__o,
    output logic [PC_W-1:0]    epc__o,
    output logic [CNT_W-1:0]   illegal_count__o
);

    localparam int unsigned CTRL_W = 8 + ALUOP_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_TRAP = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          dec_flags;
    logic [3:0]          dec_aluop;
    logic                dec_legal;
    logic [CTRL_W-1:0]   dec_ctrl;
    logic                accept_c;
    logic                issue_c;

    // Opcode decode; flags are RegDst..RegWrite, ALUOp is zero-extended.
    always_comb begin
        dec_flags = 8'b0000_0000;
        dec_aluop = 4'b0000;
        dec_legal = 1'b1;
        case (opcode__i)
            6'b000000: begin dec_flags = 8'b1000_0001; dec_aluop = 4'b0100; end
            6'b001000: begin dec_flags = 8'b0000_0011; dec_aluop = 4'b0010; end
            6'b001001: begin dec_flags = 8'b0000_0011; dec_aluop = 4'b1000; end
            6'b001010: begin dec_flags = 8'b0000_0011; dec_aluop = 4'b0110; end
            6'b001100: begin dec_flags = 8'b0000_0011; dec_aluop = 4'b0000; end
            6'b001101: begin dec_flags = 8'b0000_0011; dec_aluop = 4'b0001; end
            6'b001110: begin dec_flags = 8'b0000_0011; dec_aluop = 4'b0101; end
            6'b001111: begin dec_flags = 8'b0000_0011; dec_aluop = 4'b0111; end
            6'b100011: begin dec_flags = 8'b0001_1011; dec_aluop = 4'b0010; end
            6'b101011: begin dec_flags = 8'b0000_0110; dec_aluop = 4'b0010; end
            6'b000100: begin dec_flags = 8'b0100_0000; dec_aluop = 4'b0011; end
            6'b000101: begin dec_flags = 8'b0110_0000; dec_aluop = 4'b0011; end
            default:   dec_legal = 1'b0;
        endcase
        dec_ctrl = {dec_flags, ALUOP_W'(dec_aluop)};
    end

    // An instruction is accepted only when nothing blocks decode in ID.
    assign accept_c = valid__i & ~flush__i & ~stall__i & (state == S_IDLE);
    assign issue_c  = accept_c & dec_legal;

    // Trap FSM state register.
    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Trap FSM next state; flush never leaves TRAP, only the acknowledge does.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept_c && !dec_legal) state_nxt = S_TRAP;
            S_TRAP: if (trap_ack__i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control pipeline; EX/MEM and MEM/WB never stall.
    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            ex_ctrl__o   <= '0;
            ex_valid__o  <= 1'b0;
            mem_ctrl__o  <= '0;
            mem_valid__o <= 1'b0;
            wb_ctrl__o   <= '0;
            wb_valid__o  <= 1'b0;
        end else begin
            wb_ctrl__o   <= mem_ctrl__o;
            wb_valid__o  <= mem_valid__o;
            mem_ctrl__o  <= flush__i ? '0 : ex_ctrl__o;
            mem_valid__o <= ~flush__i & ex_valid__o;
            ex_ctrl__o   <= issue_c ? dec_ctrl : '0;
            ex_valid__o  <= issue_c;
        end
    end

    // EPC capture and saturating illegal-opcode count.
    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            epc__o           <= '0;
            illegal_count__o <= '0;
        end else if (accept_c && !dec_legal) begin
            epc__o <= pc__i;
            if (illegal_count__o != {CNT_W{1'b1}}) begin
                illegal_count__o <= illegal_count__o + CNT_W'(1);
            end
        end
    end

    assign trap__o        = (state == S_TRAP);
    assign trap_vector__o = TRAP_VECTOR;

endmodule

// File: tb/tb_cpu_control_pipe.sv
// Testbench for cpu_control_pipe: directed scenarios plus randomized traffic,
// all checked against a cycle-level reference model of the control pipeline.
module tb_cpu_control_pipe;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned CTRL_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic [5:0]        opcode;
    logic [PC_W-1:0]   pc;
    logic              stall;
    logic              flush;
    logic              ack;
    logic [CTRL_W-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic              ex_valid, mem_valid, wb_valid;
    logic              trap;
    logic [PC_W-1:0]   trap_vector, epc;
    logic [7:0]        cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: one entry per pipeline stage (0=EX,1=MEM,2=WB).
    logic [CTRL_W-1:0] m_ctrl [3];
    logic              m_valid[3];
    logic              m_trap;
    logic [PC_W-1:0]   m_epc;
    int                m_cnt;

    logic [5:0] legal_ops [12] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
                                   6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};

    cpu_control_pipe dut (
        .clock__i        (clk),
        .reset__i        (rst),
        .valid__i        (valid),
        .opcode__i       (opcode),
        .pc__i           (pc),
        .stall__i        (stall),
        .flush__i        (flush),
        .trap_ack__i     (ack),
        .ex_ctrl__o      (ex_ctrl),
        .ex_valid__o     (ex_valid),
        .mem_ctrl__o     (mem_ctrl),
        .mem_valid__o    (mem_valid),
        .wb_ctrl__o      (wb_ctrl),
        .wb_valid__o     (wb_valid),
        .trap__o         (trap),
        .trap_vector__o  (trap_vector),
        .epc__o          (epc),
        .illegal_count__o(cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Spec decode table: returns {legal, RegDst..RegWrite, ALUOp}.
    function automatic logic [12:0] ref_decode(input logic [5:0] op);
        case (op)
            6'h00: return {1'b1, 8'b1000_0001, 4'd4};
            6'h08: return {1'b1, 8'b0000_0011, 4'd2};
            6'h09: return {1'b1, 8'b0000_0011, 4'd8};
            6'h0A: return {1'b1, 8'b0000_0011, 4'd6};
            6'h0C: return {1'b1, 8'b0000_0011, 4'd0};
            6'h0D: return {1'b1, 8'b0000_0011, 4'd1};
            6'h0E: return {1'b1, 8'b0000_0011, 4'd5};
            6'h0F: return {1'b1, 8'b0000_0011, 4'd7};
            6'h23: return {1'b1, 8'b0001_1011, 4'd2};
            6'h2B: return {1'b1, 8'b0000_0110, 4'd2};
            6'h04: return {1'b1, 8'b0100_0000, 4'd3};
            6'h05: return {1'b1, 8'b0110_0000, 4'd3};
            default: return 13'd0;
        endcase
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic [12:0] d;
        logic        accepted;
        d = ref_decode(opcode);
        if (rst) begin
            for (int i = 0; i < 3; i++) begin m_ctrl[i] = '0; m_valid[i] = 1'b0; end
            m_trap = 1'b0; m_epc = '0; m_cnt = 0;
            return;
        end
        accepted = valid && !flush && !stall && !m_trap;
        m_ctrl[2] = m_ctrl[1];  m_valid[2] = m_valid[1];
        m_ctrl[1] = flush ? '0 : m_ctrl[0];
        m_valid[1] = flush ? 1'b0 : m_valid[0];
        if (accepted && d[12]) begin
            m_ctrl[0] = d[11:0]; m_valid[0] = 1'b1;
        end else begin
            m_ctrl[0] = '0; m_valid[0] = 1'b0;
        end
        if (m_trap) begin
            if (ack) m_trap = 1'b0;
        end else if (accepted && !d[12]) begin
            m_trap = 1'b1;
            m_epc  = pc;
            m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
    endtask

    task automatic check_all();
        check_eq("ex_ctrl",   32'(ex_ctrl),   32'(m_ctrl[0]));
        check_eq("ex_valid",  32'(ex_valid),  32'(m_valid[0]));
        check_eq("mem_ctrl",  32'(mem_ctrl),  32'(m_ctrl[1]));
        check_eq("mem_valid", 32'(mem_valid), 32'(m_valid[1]));
        check_eq("wb_ctrl",   32'(wb_ctrl),   32'(m_ctrl[2]));
        check_eq("wb_valid",  32'(wb_valid),  32'(m_valid[2]));
        check_eq("trap",      32'(trap),      32'(m_trap));
        check_eq("epc",       epc,            m_epc);
        check_eq("count",     32'(cnt),       32'(m_cnt));
        check_eq("trap_vec",  trap_vector,    32'h0000_0100);
    endtask

    // Drive one cycle of inputs, clock it, and compare against the model.
    task automatic step(input logic r, input logic v, input logic [5:0] op,
                        input logic [31:0] p, input logic st, input logic fl,
                        input logic ak);
        rst = r; valid = v; opcode = op; pc = p; stall = st; flush = fl; ack = ak;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; opcode = '0; pc = '0;
        stall = 1'b0; flush = 1'b0; ack = 1'b0;
        for (int i = 0; i < 3; i++) begin m_ctrl[i] = '0; m_valid[i] = 1'b0; end
        m_trap = 1'b0; m_epc = '0; m_cnt = 0;

        // 1: reset, then LW at pc 0x40 walks EX -> MEM -> WB.
        do_reset();
        check_eq("rst_ex_valid", 32'(ex_valid), 32'd0);
        step(1'b0, 1'b1, 6'h23, 32'h40, 1'b0, 1'b0, 1'b0);
        check_eq("lw_ex", 32'(ex_ctrl), 32'h1B2);
        step(1'b0, 1'b0, 6'h00, 32'h44, 1'b0, 1'b0, 1'b0);
        check_eq("lw_mem", 32'(mem_ctrl), 32'h1B2);
        step(1'b0, 1'b0, 6'h00, 32'h48, 1'b0, 1'b0, 1'b0);
        check_eq("lw_wb", 32'(wb_ctrl), 32'h1B2);

        // 2: BNE, then ANDI stalled for one cycle.
        step(1'b0, 1'b1, 6'h05, 32'h50, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'h0C, 32'h54, 1'b1, 1'b0, 1'b0);
        check_eq("stall_bubble", 32'(ex_valid), 32'd0);
        check_eq("bne_mem", 32'(mem_ctrl), 32'h603);
        step(1'b0, 1'b1, 6'h0C, 32'h54, 1'b0, 1'b0, 1'b0);
        check_eq("andi_ex", 32'(ex_ctrl), 32'h030);

        // 3: ADDI in EX, SW in ID, flush.
        step(1'b0, 1'b1, 6'h08, 32'h60, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'h2B, 32'h64, 1'b0, 1'b1, 1'b0);
        check_eq("flush_ex", 32'(ex_valid), 32'd0);
        check_eq("flush_mem", 32'(mem_valid), 32'd0);
        check_eq("flush_wb", 32'(wb_ctrl), 32'h030);

        // 4: illegal opcode at 0x88 traps; ORI blocked until ack.
        step(1'b0, 1'b1, 6'h3F, 32'h88, 1'b0, 1'b0, 1'b0);
        check_eq("trap_set", 32'(trap), 32'd1);
        check_eq("trap_epc", epc, 32'h88);
        check_eq("trap_cnt", 32'(cnt), 32'd1);
        step(1'b0, 1'b1, 6'h0D, 32'h8C, 1'b0, 1'b0, 1'b0);
        check_eq("ori_blocked", 32'(ex_valid), 32'd0);
        step(1'b0, 1'b0, 6'h0D, 32'h8C, 1'b0, 1'b1, 1'b0);
        check_eq("flush_in_trap", 32'(trap), 32'd1);
        step(1'b0, 1'b0, 6'h0D, 32'h8C, 1'b0, 1'b0, 1'b1);
        check_eq("trap_clear", 32'(trap), 32'd0);
        step(1'b0, 1'b1, 6'h0D, 32'h8C, 1'b0, 1'b0, 1'b0);
        check_eq("ori_ex", 32'(ex_ctrl), 32'h031);

        // 5: stalled illegal opcode traps only once released.
        do_reset();
        step(1'b0, 1'b1, 6'h3F, 32'h90, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'h3F, 32'h90, 1'b1, 1'b0, 1'b0);
        check_eq("stall_no_trap", 32'(trap), 32'd0);
        check_eq("stall_no_cnt", 32'(cnt), 32'd0);
        step(1'b0, 1'b1, 6'h3F, 32'h90, 1'b0, 1'b0, 1'b0);
        check_eq("released_cnt", 32'(cnt), 32'd1);

        // 6: counter saturation, then reset while trapped.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 6'h3E, 32'(i * 4), 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b1);
        end
        check_eq("cnt_sat", 32'(cnt), 32'd255);
        step(1'b0, 1'b1, 6'h3E, 32'h1234, 1'b0, 1'b0, 1'b0);
        do_reset();
        check_eq("rst_trap", 32'(trap), 32'd0);
        check_eq("rst_epc", epc, 32'd0);
        check_eq("rst_cnt", 32'(cnt), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic       r, v, st, fl, ak;
            logic [5:0] op;
            r  = ($urandom_range(0, 99) == 0);
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 7) == 0);
            ak = ($urandom_range(0, 2) == 0);
            op = ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, 11)]
                                            : 6'($urandom);
            step(r, v, op, $urandom, st, fl, ak);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
